// File: rtl/sram_rd_pkg.sv
// Shared types and width helpers for the SRAM frame reader.
package sram_rd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   // Width of a counter/index over v items, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO; push and pop may occur in the same cycle.
module pix_skid_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [1:0]       count_o,
   output logic [WIDTH-1:0] head_o
);

   logic [1:0][WIDTH-1:0] mem_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;

   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + 2'd1;
      end else if (!push_i && pop_i) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_frame_reader.sv
// Raster-order frame reader: issues SRAM reads, absorbs the one-cycle read
// latency and streams pixels with coordinates and line/frame flags.
module sram_frame_reader
   import sram_rd_pkg::*;
#(
   parameter  int unsigned WIDTH  = 8,
   parameter  int unsigned IMG_W  = 256,
   parameter  int unsigned IMG_H  = 256,
   parameter  int unsigned DEPTH  = IMG_W * IMG_H,
   localparam int unsigned ADDR_W = clog2_min1(DEPTH),
   localparam int unsigned X_W    = clog2_min1(IMG_W),
   localparam int unsigned Y_W    = clog2_min1(IMG_H)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              sram_cs_o,
   output logic              sram_write_en_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   input  logic [WIDTH-1:0]  sram_rdata_i,
   output logic              pix_valid_o,
   input  logic              pix_ready_i,
   output logic [WIDTH-1:0]  pix_data_o,
   output logic [X_W-1:0]    pix_x_o,
   output logic [Y_W-1:0]    pix_y_o,
   output logic              pix_eol_o,
   output logic              pix_last_o
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic              inflight_q;
   logic              done_q, done_d;

   logic [1:0]        fifo_count;
   logic              pop;
   logic              issue;
   logic [2:0]        occ_next;

   pix_skid_fifo #(
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (inflight_q),
      .push_data_i (sram_rdata_i),
      .pop_i       (pop),
      .count_o     (fifo_count),
      .head_o      (pix_data_o)
   );

   assign pix_valid_o = (fifo_count != 2'd0);
   assign pop         = pix_valid_o & pix_ready_i;

   // Slots committed after this cycle: buffered + in flight - leaving now.
   assign occ_next = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue    = (state_q == StRun) && (occ_next < 3'd2);

   assign pix_eol_o  = (x_q == X_W'(IMG_W - 1));
   assign pix_last_o = pix_eol_o && (y_q == Y_W'(IMG_H - 1));

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      x_d       = x_q;
      y_d       = y_q;
      done_d    = 1'b0;

      if (pop) begin
         if (pix_eol_o) begin
            x_d = '0;
            y_d = pix_last_o ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d   = StRun;
               rd_addr_d = '0;
               x_d       = '0;
               y_d       = '0;
            end
         end
         StRun: begin
            if (issue) begin
               if (rd_addr_q == ADDR_W'(DEPTH - 1)) begin
                  state_d = StDrain;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (pop && pix_last_o) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         rd_addr_q  <= '0;
         x_q        <= '0;
         y_q        <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         inflight_q <= issue;
         done_q     <= done_d;
      end
   end

   assign busy_o          = (state_q != StIdle);
   assign done_o          = done_q;
   assign sram_cs_o       = issue;
   assign sram_write_en_o = 1'b0;
   assign sram_addr_o     = issue ? rd_addr_q : '0;
   assign pix_x_o         = x_q;
   assign pix_y_o         = y_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Self-checking bench for sram_frame_reader on a 4x2 frame with mem[a] = a + 0x10.
module tb_sram_frame_reader;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned IMG_W = 4;
   localparam int unsigned IMG_H = 2;
   localparam int unsigned DEPTH = IMG_W * IMG_H;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       sram_cs;
   logic       sram_we;
   logic [2:0] sram_addr;
   logic [7:0] sram_rdata = 8'h00;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_data;
   logic [1:0] pix_x;
   logic       pix_y;
   logic       pix_eol;
   logic       pix_last;

   sram_frame_reader #(
      .WIDTH (WIDTH),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .busy_o          (busy),
      .done_o          (done),
      .sram_cs_o       (sram_cs),
      .sram_write_en_o (sram_we),
      .sram_addr_o     (sram_addr),
      .sram_rdata_i    (sram_rdata),
      .pix_valid_o     (pix_valid),
      .pix_ready_i     (pix_ready),
      .pix_data_o      (pix_data),
      .pix_x_o         (pix_x),
      .pix_y_o         (pix_y),
      .pix_eol_o       (pix_eol),
      .pix_last_o      (pix_last)
   );

   always #5 clk = ~clk;

   // Registered-address SRAM model
   logic [7:0] mem [DEPTH];
   initial for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a + 8'h10);
   always @(posedge clk) if (sram_cs) sram_rdata <= mem[sram_addr];

   typedef struct {
      logic [7:0] d;
      logic [1:0] x;
      logic       y;
      logic       eol;
      logic       last;
   } beat_t;

   typedef struct {
      int mode;       // 0 ready=1, 1 toggle, 2 stall 2..9, 3 start re-pulse, 4 start in done cycle
      int exp_beats;
      int exp_dones;
   } vec_t;

   beat_t sb_q[$];
   vec_t  vecs[5];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int beats, issued, done_cnt, done_cyc, first_valid_cyc;
   int exp_addr;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pack(input logic [7:0] d, input logic [1:0] x, input logic y,
                                        input logic eol, input logic last);
      return {19'd0, d, x, y, eol, last};
   endfunction

   task automatic push_frame();
      beat_t b;
      for (int a = 0; a < DEPTH; a++) begin
         b.d    = 8'(a + 8'h10);
         b.x    = 2'(a % IMG_W);
         b.y    = 1'(a / IMG_W);
         b.eol  = ((a % IMG_W) == IMG_W - 1);
         b.last = (a == DEPTH - 1);
         sb_q.push_back(b);
      end
   endtask

   task automatic clear_counters();
      beats = 0; issued = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; exp_addr = 0;
   endtask

   // Monitor / scoreboard, sampling on the falling edge
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("write_en_low", sram_we, 0);
         if (sram_cs) begin
            check("issue_addr", sram_addr, exp_addr);
            exp_addr++;
            issued++;
         end else begin
            check("addr_zero_when_idle", sram_addr, 0);
         end
         if (prev_stall) begin
            check("stall_valid_held", pix_valid, 1);
            check("stall_data_held", pix_data, prev_data);
         end
         if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (pix_valid && pix_ready) begin
            beats++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got data 0x%0h expected no beat", pix_data);
            end else begin
               e = sb_q.pop_front();
               check("beat", pack(pix_data, pix_x, pix_y, pix_eol, pix_last),
                     pack(e.d, e.x, e.y, e.eol, e.last));
            end
         end
         check("occupancy_le2", 32'((issued - beats) <= 2), 1);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         prev_stall = pix_valid && !pix_ready;
         prev_data  = pix_data;
      end
   end

   task automatic do_frame(input vec_t v);
      int extra;
      @(posedge clk); #1;
      cyc = 0;
      clear_counters();
      start     = 1'b1;
      pix_ready = 1'b1;
      push_frame();
      extra = 0;
      for (int c = 1; c < 200 && extra < 6; c++) begin
         @(posedge clk); #1;
         cyc   = c;
         start = 1'b0;
         if (v.mode == 3 && c == 4) start = 1'b1;
         if (v.mode == 4 && c == 11) begin
            start    = 1'b1;
            exp_addr = 0;
            push_frame();
         end
         case (v.mode)
            1:       pix_ready = (c % 2 == 0);
            2:       pix_ready = !(c >= 2 && c <= 9);
            default: pix_ready = 1'b1;
         endcase
         @(negedge clk); #1;
         if (v.mode == 0 && c == 10) check("last_beat_cycle10", {pix_valid, pix_last}, 2'b11);
         if (v.mode == 0 && c == 11) check("busy_low_at_done", {done, busy}, 2'b10);
         if (v.mode == 2 && c == 9) begin
            check("stall_reads_issued", issued, 2);
            check("stall_cs_low", sram_cs, 0);
            check("stall_head", {pix_valid, pix_data}, {1'b1, 8'h10});
         end
         if (v.mode == 3 && c == 5) check("busy_during_repulse", busy, 1);
         if (v.mode == 4 && c == 12) check("restart_issue_addr0", {sram_cs, sram_addr}, 4'b1000);
         if (done_cnt >= v.exp_dones) extra++;
      end
      start = 1'b0;
      check($sformatf("mode%0d_beats", v.mode), beats, v.exp_beats);
      check($sformatf("mode%0d_dones", v.mode), done_cnt, v.exp_dones);
      check($sformatf("mode%0d_sb_drained", v.mode), sb_q.size(), 0);
      check($sformatf("mode%0d_idle", v.mode), busy, 0);
      if (v.mode == 0) begin
         check("first_valid_cycle", first_valid_cyc, 3);
         check("done_cycle", done_cyc, 11);
      end
   endtask

   initial begin
      vecs[0] = '{mode: 0, exp_beats: 8,  exp_dones: 1};
      vecs[1] = '{mode: 1, exp_beats: 8,  exp_dones: 1};
      vecs[2] = '{mode: 2, exp_beats: 8,  exp_dones: 1};
      vecs[3] = '{mode: 3, exp_beats: 8,  exp_dones: 1};
      vecs[4] = '{mode: 4, exp_beats: 16, exp_dones: 2};

      clear_counters();
      rst       = 1'b1;
      start     = 1'b0;
      pix_ready = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cs_addr", {sram_cs, sram_addr}, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_pix", {pix_data, pix_x, pix_y}, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) do_frame(vecs[i]);

      // Asynchronous reset after three accepted beats
      @(posedge clk); #1;
      cyc = 0;
      clear_counters();
      start     = 1'b1;
      pix_ready = 1'b1;
      push_frame();
      for (int c = 1; c < 50 && beats < 3; c++) begin
         @(posedge clk); #1;
         cyc   = c;
         start = 1'b0;
         @(negedge clk); #1;
      end
      check("beats_before_rst", beats, 3);
      check("busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_cs_addr", {sram_cs, sram_addr}, 0);
      check("midrst_valid", pix_valid, 0);
      check("midrst_pix", {pix_data, pix_x, pix_y}, 0);
      check("midrst_no_done", done_cnt, 0);
      sb_q.delete();
      clear_counters();
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      do_frame(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
